eq_biquad_cascade: RTL and testbench

EQ_BIQUAD_CASCADE -- requirements
Module: eq_biquad_cascade

---
 rtl/eq_pkg.sv | 50 +++++
 rtl/eq_mac.sv | 48 ++++
 rtl/eq_biquad_cascade.sv | 241 ++++++++++++++++++++++++
 tb/tb_eq_biquad_cascade.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared definitions for the biquad cascade: FSM states, tap ordering and
// the round/saturate helper used at the end of each section.
package eq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAC    = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } eq_state_e;

    // Tap order inside a section; also the coefficient offset within sect*5.
    localparam int TAP_B0 = 0;
    localparam int TAP_B1 = 1;
    localparam int TAP_B2 = 2;
    localparam int TAP_A1 = 3;
    localparam int TAP_A2 = 4;
    localparam int N_TAPS = 5;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } rs_t;

    // Round half-up by 2^(frac-1), arithmetic shift by frac, clamp to a
    // data_w-bit signed range. The accumulator is sign-extended to 64 bits
    // by the caller so the rounding add can never wrap.
    function automatic rs_t round_sat(input logic signed [63:0] acc,
                                      input int frac,
                                      input int data_w);
        logic signed [63:0] rnd;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        rs_t r;
        rnd = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi  = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (data_w - 1));
        r.sat = 1'b0;
        r.val = rnd;
        if (rnd > hi) begin
            r.sat = 1'b1;
            r.val = hi;
        end else if (rnd < lo) begin
            r.sat = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/eq_mac.sv
// Single shared multiplier with an accumulate/subtract register.
// clr_i has priority over en_i and zeroes the accumulator.
module eq_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic                     sub_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic signed [COEF_W-1:0] coef_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    // Full-precision product and next accumulator value.
    always_comb begin
        prod     = PROD_W'(sample_i) * PROD_W'(coef_i);
        prod_ext = ACC_W'(prod);
        acc_d    = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sub_i ? (acc_q - prod_ext) : (acc_q + prod_ext);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/eq_biquad_cascade.sv
// Cascade of N_SECT Direct Form I biquads sharing one multiplier.
// Each section takes five MAC cycles plus one UPDATE cycle.
module eq_biquad_cascade
    import eq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = 14,
    parameter int N_SECT = 2,
    parameter int ACC_W  = 40
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              x_in,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              y_out,
    input  logic                           bypass,
    input  logic                           clr_state,
    input  logic                           coef_we,
    input  logic [$clog2(5*N_SECT)-1:0]    coef_addr,
    input  logic [COEF_W-1:0]              coef_wdata,
    output logic                           sat_flag
);

    localparam int N_COEF = N_TAPS * N_SECT;
    localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(2 ** FRAC);

    eq_state_e state_q, state_d;
    logic [3:0] sect_q, sect_d;
    logic [2:0] tap_q, tap_d;
    logic signed [DATA_W-1:0] xcur_q, xcur_d;
    logic [DATA_W-1:0] yout_q, yout_d;
    logic sat_q, sat_d;

    logic mac_clr, mac_en, mac_sub;
    logic signed [DATA_W-1:0] mac_op;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [ACC_W-1:0]  mac_acc;

    logic signed [COEF_W-1:0] coef_w [N_COEF];
    logic signed [DATA_W-1:0] x1_w [N_SECT];
    logic signed [DATA_W-1:0] x2_w [N_SECT];
    logic signed [DATA_W-1:0] y1_w [N_SECT];
    logic signed [DATA_W-1:0] y2_w [N_SECT];
    logic signed [DATA_W-1:0] x1_sel, x2_sel, y1_sel, y2_sel;

    rs_t rs;
    logic signed [DATA_W-1:0] y_new;
    logic unused_rs_bits;

    logic idle;
    assign idle = (state_q == IDLE);

    // Section result: round, shift and clamp the finished accumulator.
    always_comb begin
        rs    = round_sat(64'(mac_acc), FRAC, DATA_W);
        y_new = rs.val[DATA_W-1:0];
    end
    assign unused_rs_bits = ^rs.val[63:DATA_W];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, handshake outputs and datapath next values.
    always_comb begin
        state_d   = state_q;
        sect_d    = sect_q;
        tap_d     = tap_q;
        xcur_d    = xcur_q;
        yout_d    = yout_q;
        sat_d     = sat_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    xcur_d  = x_in;
                    sect_d  = '0;
                    tap_d   = '0;
                    mac_clr = 1'b1;
                    if (bypass) begin
                        yout_d  = x_in;
                        state_d = DONE;
                    end else begin
                        state_d = MAC;
                    end
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (tap_q == 3'(TAP_A2)) begin
                    tap_d   = '0;
                    state_d = UPDATE;
                end else begin
                    tap_d = tap_q + 3'd1;
                end
            end
            UPDATE: begin
                mac_clr = 1'b1;
                xcur_d  = y_new;
                sat_d   = sat_q | rs.sat;
                if (sect_q == 4'(N_SECT - 1)) begin
                    yout_d  = y_new;
                    state_d = DONE;
                end else begin
                    sect_d  = sect_q + 4'd1;
                    state_d = MAC;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: section/tap counters, current input, output, flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sect_q <= '0;
            tap_q  <= '0;
            xcur_q <= '0;
            yout_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            sect_q <= sect_d;
            tap_q  <= tap_d;
            xcur_q <= xcur_d;
            yout_q <= yout_d;
            sat_q  <= sat_d;
        end
    end

    // Operand selection for the current section and tap; feedback taps subtract.
    always_comb begin
        coef_sel = '0;
        x1_sel   = '0;
        x2_sel   = '0;
        y1_sel   = '0;
        y2_sel   = '0;
        for (int k = 0; k < N_COEF; k++) begin
            if (k == int'(sect_q) * N_TAPS + int'(tap_q)) begin
                coef_sel = coef_w[k];
            end
        end
        for (int s = 0; s < N_SECT; s++) begin
            if (s == int'(sect_q)) begin
                x1_sel = x1_w[s];
                x2_sel = x2_w[s];
                y1_sel = y1_w[s];
                y2_sel = y2_w[s];
            end
        end
        case (tap_q)
            3'(TAP_B0): mac_op = xcur_q;
            3'(TAP_B1): mac_op = x1_sel;
            3'(TAP_B2): mac_op = x2_sel;
            3'(TAP_A1): mac_op = y1_sel;
            default:    mac_op = y2_sel;
        endcase
        mac_sub = (tap_q >= 3'(TAP_A1));
    end

    eq_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (mac_clr),
        .en_i     (mac_en),
        .sub_i    (mac_sub),
        .sample_i (mac_op),
        .coef_i   (coef_sel),
        .acc_o    (mac_acc)
    );

    // Coefficient bank: unity b0 on reset, writable only while idle.
    // Addresses past the last section never match any entry and are dropped.
    generate
        for (genvar gi = 0; gi < N_COEF; gi++) begin : g_coef
            logic signed [COEF_W-1:0] coef_q;
            // One coefficient register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    coef_q <= ((gi % N_TAPS) == TAP_B0) ? UNITY : '0;
                end else if (idle && coef_we && (int'(coef_addr) == gi)) begin
                    coef_q <= coef_wdata;
                end
            end
            assign coef_w[gi] = coef_q;
        end
    endgenerate

    // Per-section history; shifted only when that section finishes.
    generate
        for (genvar gi = 0; gi < N_SECT; gi++) begin : g_sect
            logic signed [DATA_W-1:0] x1_q, x2_q, y1_q, y2_q;
            // History shift or clear for this section.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x1_q <= '0;
                    x2_q <= '0;
                    y1_q <= '0;
                    y2_q <= '0;
                end else if (idle && clr_state) begin
                    x1_q <= '0;
                    x2_q <= '0;
                    y1_q <= '0;
                    y2_q <= '0;
                end else if ((state_q == UPDATE) && (int'(sect_q) == gi)) begin
                    x2_q <= x1_q;
                    x1_q <= xcur_q;
                    y2_q <= y1_q;
                    y1_q <= y_new;
                end
            end
            assign x1_w[gi] = x1_q;
            assign x2_w[gi] = x2_q;
            assign y1_w[gi] = y1_q;
            assign y2_w[gi] = y2_q;
        end
    endgenerate

    assign y_out    = yout_q;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_eq_biquad_cascade.sv
// Scoreboard bench for eq_biquad_cascade: the driver pushes expected results
// computed by an arithmetic reference model; a monitor pops on out_valid.
module tb_eq_biquad_cascade;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int FR = 14;
    localparam int NS = 2;
    localparam int NC = 5 * NS;
    localparam int AW = $clog2(5 * NS);
    localparam int FILT_LAT = 6 * NS + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic bypass = 1'b0;
    logic clr_state = 1'b0;
    logic coef_we = 1'b0;
    logic [DW-1:0] x_in = '0;
    logic [AW-1:0] coef_addr = '0;
    logic [CW-1:0] coef_wdata = '0;
    logic in_ready, out_valid, sat_flag;
    logic [DW-1:0] y_out;

    eq_biquad_cascade #(
        .DATA_W (DW), .COEF_W (CW), .FRAC (FR), .N_SECT (NS), .ACC_W (40)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x_in       (x_in),
        .out_valid  (out_valid),
        .y_out      (y_out),
        .bypass     (bypass),
        .clr_state  (clr_state),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state.
    int     m_coef [NC];
    longint m_x1 [NS];
    longint m_x2 [NS];
    longint m_y1 [NS];
    longint m_y2 [NS];
    bit     m_sat;

    typedef struct {
        int y;
        bit sat;
        int lat;
        int acc_cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   last_y = 0;

    function automatic void model_clear();
        for (int s = 0; s < NS; s++) begin
            m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NC; k++) m_coef[k] = ((k % 5) == 0) ? (1 << FR) : 0;
        model_clear();
        m_sat = 1'b0;
    endfunction

    function automatic int model_step(int x, bit byp);
        longint v, acc, r;
        if (byp) return x;
        v = x;
        for (int s = 0; s < NS; s++) begin
            acc = longint'(m_coef[s*5+0]) * v
                + longint'(m_coef[s*5+1]) * m_x1[s]
                + longint'(m_coef[s*5+2]) * m_x2[s]
                - longint'(m_coef[s*5+3]) * m_y1[s]
                - longint'(m_coef[s*5+4]) * m_y2[s];
            r = (acc + (longint'(1) << (FR - 1))) >>> FR;
            if (r > 32767)  begin r = 32767;  m_sat = 1'b1; end
            if (r < -32768) begin r = -32768; m_sat = 1'b1; end
            m_x2[s] = m_x1[s]; m_x1[s] = v;
            m_y2[s] = m_y1[s]; m_y1[s] = r;
            v = r;
        end
        return int'(v);
    endfunction

    task automatic chk(input string nm, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, got, req);
        end else begin
            $display("check %s: %0d", nm, got);
        end
    endtask

    // Present one sample, hold it until accepted, then push the expectation.
    task automatic send(input int x, input bit byp, input bit clr, input bit push,
                        input bit ovr_en, input int ovr_y);
        bit   accepted = 1'b0;
        bit   rdy;
        exp_t e;
        in_valid  = 1'b1;
        x_in      = DW'(x);
        bypass    = byp;
        clr_state = clr;
        for (int k = 0; k < 300 && !accepted; k++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) accepted = 1'b1;
        end
        in_valid  = 1'b0;
        bypass    = 1'b0;
        clr_state = 1'b0;
        if (!accepted) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: sample %0d not accepted within 300 cycles", x);
        end else if (push) begin
            if (clr) model_clear();
            e.y       = model_step(x, byp);
            if (ovr_en) e.y = ovr_y;
            e.sat     = m_sat;
            e.lat     = byp ? 1 : FILT_LAT;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (sb.size() == 0 && in_ready) begin ok = 1'b1; break; end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL idle_timeout: %0d results still pending", sb.size());
        end
    endtask

    task automatic write_coef(input int addr, input int val, input bit is_idle);
        coef_we    = 1'b1;
        coef_addr  = AW'(addr);
        coef_wdata = CW'(val);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        if (is_idle && addr < NC) m_coef[addr] = val;
    endtask

    task automatic prog0(input int b0, input int b1, input int b2, input int a1, input int a2);
        wait_idle();
        write_coef(0, b0, 1);
        write_coef(1, b1, 1);
        write_coef(2, b2, 1);
        write_coef(3, a1, 1);
        write_coef(4, a2, 1);
    endtask

    task automatic clear_hist();
        wait_idle();
        clr_state = 1'b1;
        @(posedge clk);
        #1;
        clr_state = 1'b0;
        model_clear();
    endtask

    // Monitor: pop and compare on out_valid; otherwise check hold and busy.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_y = 0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL spurious_out: out_valid=1 y_out=%0d with nothing pending", $signed(y_out));
            end else begin
                mon_e = sb.pop_front();
                n_cmp++;
                if (int'($signed(y_out)) != mon_e.y || sat_flag != mon_e.sat ||
                    (cyc - mon_e.acc_cyc + 1) != mon_e.lat) begin
                    n_fail++;
                    $display("FAIL txn: got y=%0d sat=%0d lat=%0d required y=%0d sat=%0d lat=%0d",
                             $signed(y_out), sat_flag, cyc - mon_e.acc_cyc + 1,
                             mon_e.y, mon_e.sat, mon_e.lat);
                end else begin
                    $display("txn y=%0d sat=%0d lat=%0d", $signed(y_out), sat_flag,
                             cyc - mon_e.acc_cyc + 1);
                end
            end
            last_y = int'($signed(y_out));
        end else begin
            if (int'($signed(y_out)) != last_y) begin
                n_fail++;
                $display("FAIL y_hold: got %0d required %0d", $signed(y_out), last_y);
            end
            if (sb.size() > 0 && in_ready) begin
                n_fail++;
                $display("FAIL busy_ready: got in_ready=1 required 0");
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_sat_flag", int'(sat_flag), 0);

        // Unprogrammed block passes data through with full filtered latency.
        send(1000, 0, 0, 1, 1, 1000);
        send(-1234, 1, 0, 1, 1, -1234);

        // FIR with three quarter taps.
        prog0(4096, 4096, 4096, 0, 0);
        clear_hist();
        send(16000, 0, 0, 1, 1, 4000);
        send(0, 0, 0, 1, 1, 4000);
        send(0, 0, 0, 1, 1, 4000);
        send(0, 0, 0, 1, 1, 0);

        // Single-pole recursion y = x + 0.5*y1.
        prog0(16384, 0, 0, -8192, 0);
        clear_hist();
        send(16384, 0, 0, 1, 1, 16384);
        send(0, 0, 0, 1, 1, 8192);
        send(0, 0, 0, 1, 1, 4096);
        send(0, 0, 0, 1, 1, 2048);

        // Positive overflow clamps and latches the sticky flag.
        prog0(32767, 0, 0, 0, 0);
        clear_hist();
        send(32767, 0, 0, 1, 1, 32767);
        send(100, 0, 0, 1, 0, 0);
        send(-500, 1, 0, 1, 1, -500);

        // Randomised coefficients, samples, bypass, clears and stray writes.
        wait_idle();
        for (int k = 0; k < NC; k++) write_coef(k, int'($urandom_range(0, 16384)) - 8192, 1);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                wait_idle();
                write_coef(int'($urandom_range(0, 15)), int'($urandom_range(0, 16384)) - 8192, 1);
            end
            send(int'($urandom_range(0, 65535)) - 32768, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0), 1, 0, 0);
        end

        // Busy write is dropped; held sample waits for IDLE.
        prog0(8192, 0, 0, 0, 0);
        clear_hist();
        for (int k = 5; k < NC; k++) write_coef(k, ((k % 5) == 0) ? 16384 : 0, 1);
        send(2000, 0, 0, 1, 1, 1000);
        write_coef(0, 16384, 0);
        send(4000, 0, 0, 1, 1, 2000);

        // Reset in the middle of a computation aborts it silently.
        wait_idle();
        send(3000, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_y_out", int'(y_out), 0);
        chk("abort_sat_flag", int'(sat_flag), 0);
        repeat (20) @(posedge clk);
        #1;
        send(1000, 0, 0, 1, 1, 1000);
        wait_idle();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
